// File: rtl/npc_ras_if.sv
// Request/response bundle between the multi-cycle control path and the next-PC unit.
// NPC_ALIGN_CHECK_EN adds the misalign pulse to the bundle.
interface npc_ras_if #(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 4
);
  localparam int CW = $clog2(RAS_DEPTH) + 1;

  logic            pc_wr;
  logic [2:0]      pc_src;
  logic [XLEN-1:0] imm32;
  logic [25:0]     imm26;
  logic [XLEN-1:0] bus_a;
  logic            exc;
  logic            is_call;

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc4;
  logic [XLEN-1:0] next_pc;
  logic [XLEN-1:0] ras_top;
  logic            ras_valid;
  logic [CW-1:0]   ras_count;
  logic            ras_mispredict;
  logic            ras_overflow;
`ifdef NPC_ALIGN_CHECK_EN
  logic            misalign;

  modport master (
    output pc_wr, pc_src, imm32, imm26, bus_a, exc, is_call,
    input  pc, pc4, next_pc, ras_top, ras_valid, ras_count,
           ras_mispredict, ras_overflow, misalign
  );
  modport slave (
    input  pc_wr, pc_src, imm32, imm26, bus_a, exc, is_call,
    output pc, pc4, next_pc, ras_top, ras_valid, ras_count,
           ras_mispredict, ras_overflow, misalign
  );
`else
  modport master (
    output pc_wr, pc_src, imm32, imm26, bus_a, exc, is_call,
    input  pc, pc4, next_pc, ras_top, ras_valid, ras_count,
           ras_mispredict, ras_overflow
  );
  modport slave (
    input  pc_wr, pc_src, imm32, imm26, bus_a, exc, is_call,
    output pc, pc4, next_pc, ras_top, ras_valid, ras_count,
           ras_mispredict, ras_overflow
  );
`endif
endinterface

// File: rtl/npc_ras.sv
// Next-PC unit with PC register and a circular return-address stack that checks return targets.
// Optional NPC_ALIGN_CHECK_EN: misaligned register targets trap to EXC_VEC and pulse misalign.
module npc_ras #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter logic [XLEN-1:0] EXC_VEC   = XLEN'(32'h0000_0080),
  parameter int              RAS_DEPTH = 4
) (
  input logic      clk,
  input logic      reset,
  npc_ras_if.slave bus
);
  localparam int            PW   = $clog2(RAS_DEPTH);
  localparam int            CW   = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(RAS_DEPTH);

  logic [XLEN-1:0]                pc_q, pc4, br_tgt, j_tgt, nxt, top;
  logic [RAS_DEPTH-1:0][XLEN-1:0] stk;
  logic [PW-1:0]                  ptr, ptr_m1;
  logic [CW-1:0]                  cnt;
  logic                           mis_q, ovf_q;
  logic                           is_ret, reg_src, bad_al, ras_en, empty, full;
  logic                           do_push, do_pop, do_repl, do_chk;

  assign pc4     = pc_q + XLEN'(4);
  assign br_tgt  = pc4 + (bus.imm32 << 2);
  assign j_tgt   = {pc4[XLEN-1:28], bus.imm26, 2'b00};
  assign is_ret  = bus.pc_src == 3'd4;
  assign reg_src = (bus.pc_src == 3'd2) || is_ret;

`ifdef NPC_ALIGN_CHECK_EN
  assign bad_al = reg_src && !bus.exc && (bus.bus_a[1:0] != 2'b00);
`else
  assign bad_al = 1'b0;
`endif

  always_comb begin
    nxt = pc4;
    if (reset)                  nxt = RESET_VEC;
    else if (bus.exc || bad_al) nxt = EXC_VEC;
    else if (reg_src)           nxt = bus.bus_a;
    else begin
      case (bus.pc_src)
        3'd1:    nxt = br_tgt;
        3'd3:    nxt = j_tgt;
        default: nxt = pc4;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset)
    if (reset)           pc_q <= RESET_VEC;
    else if (bus.pc_wr)  pc_q <= nxt;

  // ptr is the next free slot; top of stack lives one below it.
  assign ptr_m1 = ptr - PW'(1);
  assign empty  = cnt == '0;
  assign full   = cnt == FULL;
  assign top    = empty ? '0 : stk[ptr_m1];

  // Traps and misaligned targets leave the stack untouched.
  assign ras_en  = bus.pc_wr && !bus.exc && !bad_al;
  assign do_chk  = ras_en && is_ret;
  assign do_push = ras_en && bus.is_call && (!is_ret || empty);
  assign do_pop  = ras_en && is_ret && !bus.is_call && !empty;
  assign do_repl = ras_en && is_ret && bus.is_call && !empty;

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      ptr   <= '0;
      cnt   <= '0;
      mis_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      // Empty-stack returns count as mispredicts, hence no compare against the 0 default.
      mis_q <= do_chk && (empty || (top != bus.bus_a));
      ovf_q <= do_push && full;
      if (do_push) begin
        ptr <= ptr + PW'(1);
        if (!full) cnt <= cnt + CW'(1);
      end else if (do_pop) begin
        ptr <= ptr_m1;
        cnt <= cnt - CW'(1);
      end
    end

  always_ff @(posedge clk)
    if (do_push)      stk[ptr]    <= pc4;
    else if (do_repl) stk[ptr_m1] <= pc4;

`ifdef NPC_ALIGN_CHECK_EN
  logic mal_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) mal_q <= 1'b0;
    else       mal_q <= bus.pc_wr && bad_al;
  assign bus.misalign = mal_q;
`endif

  assign bus.pc             = pc_q;
  assign bus.pc4            = pc4;
  assign bus.next_pc        = nxt;
  assign bus.ras_top        = top;
  assign bus.ras_valid      = !empty;
  assign bus.ras_count      = cnt;
  assign bus.ras_mispredict = mis_q;
  assign bus.ras_overflow   = ovf_q;
endmodule

// File: tb/tb_npc_ras.sv
// Directed bench for npc_ras: queue-based reference model checked every cycle plus literal pins.
module tb_npc_ras;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RV    = 32'h0;
  localparam logic [31:0] EV    = 32'h80;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;

  npc_ras_if #(.XLEN(32), .RAS_DEPTH(DEPTH)) bus ();

  npc_ras #(.XLEN(32), .RESET_VEC(RV), .EXC_VEC(EV), .RAS_DEPTH(DEPTH)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: PC value plus a bounded queue of return addresses (back = top).
  logic [31:0] mpc;
  logic [31:0] rq[$];
  bit          mmis, movf, mmal;

  function automatic bit m_bad_al();
`ifdef NPC_ALIGN_CHECK_EN
    return (bus.pc_src == 3'd2 || bus.pc_src == 3'd4) && !bus.exc && bus.bus_a[1:0] != 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] m_next();
    logic [31:0] p4;
    p4 = mpc + 32'd4;
    if (reset)                      return RV;
    if (bus.exc || m_bad_al())      return EV;
    case (bus.pc_src)
      3'd1:       return p4 + {bus.imm32[29:0], 2'b00};
      3'd2, 3'd4: return bus.bus_a;
      3'd3:       return {p4[31:28], bus.imm26, 2'b00};
      default:    return p4;
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin
    logic [31:0] p4, nx;
    bit ret, en;
    if (reset) begin
      mpc = RV; rq.delete(); mmis = 0; movf = 0; mmal = 0;
    end else begin
      p4   = mpc + 32'd4;
      nx   = m_next();
      ret  = bus.pc_src == 3'd4;
      en   = bus.pc_wr && !bus.exc && !m_bad_al();
      mmis = 0;
      movf = 0;
      mmal = bus.pc_wr && m_bad_al();
      if (en && ret) mmis = (rq.size() == 0) || (rq[rq.size()-1] != bus.bus_a);
      if (en) begin
        if (bus.is_call && (!ret || rq.size() == 0)) begin
          if (rq.size() == DEPTH) begin void'(rq.pop_front()); movf = 1; end
          rq.push_back(p4);
        end else if (ret && !bus.is_call) begin
          if (rq.size() > 0) void'(rq.pop_back());
        end else if (ret && bus.is_call) begin
          rq[rq.size()-1] = p4;
        end
      end
      if (bus.pc_wr) mpc = nx;
    end
  end

  always @(negedge clk) begin
    chk("pc", bus.pc, mpc);
    chk("pc4", bus.pc4, mpc + 32'd4);
    chk("next_pc", bus.next_pc, m_next());
    chk("ras_top", bus.ras_top, rq.size() != 0 ? rq[rq.size()-1] : 32'h0);
    chk("ras_valid", 32'(bus.ras_valid), 32'(rq.size() != 0));
    chk("ras_count", 32'(bus.ras_count), 32'(rq.size()));
    chk("ras_mispredict", 32'(bus.ras_mispredict), 32'(mmis));
    chk("ras_overflow", 32'(bus.ras_overflow), 32'(movf));
`ifdef NPC_ALIGN_CHECK_EN
    chk("misalign", 32'(bus.misalign), 32'(mmal));
`endif
  end

  task automatic drive(input bit wr, input logic [2:0] src, input bit call, input bit ex,
                       input logic [31:0] a, input logic [31:0] i32 = 0, input logic [25:0] i26 = 0);
    bus.pc_wr = wr; bus.pc_src = src; bus.is_call = call; bus.exc = ex;
    bus.bus_a = a; bus.imm32 = i32; bus.imm26 = i26;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic load(input logic [31:0] v);
    drive(1, 3'd2, 0, 0, v); tick(); drive(0, 3'd0, 0, 0, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_top[4];
    exp_top = '{32'h44, 32'h34, 32'h24, 32'h14};
    drive(0, 3'd0, 0, 0, 0);
    tick(); tick();
    reset = 1'b0;
    chk("rst_pc", bus.pc, 32'h0);
    chk("rst_count", 32'(bus.ras_count), 32'h0);

    drive(1, 3'd0, 0, 0, 0);
    tick(); chk("seq1", bus.pc, 32'h4);
    tick(); chk("seq2", bus.pc, 32'h8);
    tick(); chk("seq3", bus.pc, 32'hC);
    drive(0, 3'd0, 0, 0, 0);
    tick(); chk("hold", bus.pc, 32'hC);

    load(32'h40); chk("load40", bus.pc, 32'h40);
    drive(1, 3'd2, 0, 0, 32'h40);
    reset = 1'b1; #1;
    chk("async_rst_pc", bus.pc, 32'h0);
    chk("rst_next_pc", bus.next_pc, RV);
    tick(); reset = 1'b0;
    drive(0, 3'd0, 0, 0, 0);

    load(32'h1000);
    drive(0, 3'd1, 0, 0, 0, 32'hFFFF_FFFE); #1;
    chk("branch", bus.next_pc, 32'h0000_0FFC);
    load(32'h1000_0000);
    drive(0, 3'd3, 0, 0, 0, 0, 26'h100); #1;
    chk("jump", bus.next_pc, 32'h1000_0400);
    load(32'hFFFF_FFFC);
    drive(0, 3'd0, 0, 0, 0); #1;
    chk("seq_wrap", bus.next_pc, 32'h0);
    drive(0, 3'd6, 0, 0, 32'h500); #1;
    chk("src6_seq", bus.next_pc, 32'h0);

    load(32'h100);
    drive(1, 3'd0, 1, 0, 0); tick();
    chk("call_pc", bus.pc, 32'h104);
    chk("call_top", bus.ras_top, 32'h104);
    drive(1, 3'd4, 0, 0, 32'h104); tick();
    chk("ret_pc", bus.pc, 32'h104);
    chk("ret_mis", 32'(bus.ras_mispredict), 32'h0);
    chk("ret_count", 32'(bus.ras_count), 32'h0);

    load(32'h0);
    for (int i = 0; i < 5; i++) begin
      drive(1, 3'd2, 1, 0, 32'((i + 1) * 16)); tick();
      if (i == 3) chk("no_ovf_4th", 32'(bus.ras_overflow), 32'h0);
    end
    chk("ovf_pulse", 32'(bus.ras_overflow), 32'h1);
    chk("ovf_count", 32'(bus.ras_count), 32'h4);
    for (int i = 0; i < 4; i++) begin
      drive(1, 3'd4, 0, 0, exp_top[i]); #1;
      chk("pop_top", bus.ras_top, exp_top[i]);
      tick();
      chk("pop_mis", 32'(bus.ras_mispredict), 32'h0);
    end
    chk("pop_count", 32'(bus.ras_count), 32'h0);
    drive(1, 3'd4, 0, 0, 32'h0); tick();
    chk("underflow_mis", 32'(bus.ras_mispredict), 32'h1);
    chk("underflow_count", 32'(bus.ras_count), 32'h0);
    drive(0, 3'd0, 0, 0, 0); tick();
    chk("mis_one_cycle", 32'(bus.ras_mispredict), 32'h0);

    drive(1, 3'd0, 1, 0, 0); tick();
    drive(1, 3'd4, 0, 0, 32'hDEAD_BEE0); tick();
    chk("wrong_tgt_mis", 32'(bus.ras_mispredict), 32'h1);

    drive(1, 3'd2, 1, 0, 32'h200); tick();
    drive(1, 3'd4, 1, 0, 32'hDEAD_BEE4); tick();
    chk("callret_mis", 32'(bus.ras_mispredict), 32'h0);
    chk("callret_top", bus.ras_top, 32'h204);
    chk("callret_count", 32'(bus.ras_count), 32'h1);

    drive(1, 3'd1, 1, 1, 0, 32'h5); tick();
    chk("exc_pc", bus.pc, EV);
    chk("exc_count", 32'(bus.ras_count), 32'h1);
    chk("exc_ovf", 32'(bus.ras_overflow), 32'h0);
    drive(0, 3'd4, 0, 0, 32'h204); tick();
    chk("nowr_count", 32'(bus.ras_count), 32'h1);
    chk("nowr_pc", bus.pc, EV);

    drive(1, 3'd2, 0, 0, 32'h202); tick();
`ifdef NPC_ALIGN_CHECK_EN
    chk("align_pc", bus.pc, EV);
    chk("align_pulse", 32'(bus.misalign), 32'h1);
    drive(0, 3'd0, 0, 0, 0); tick();
    chk("align_one_cycle", 32'(bus.misalign), 32'h0);
`else
    chk("noalign_pc", bus.pc, 32'h202);
    drive(0, 3'd0, 0, 0, 0); tick();
`endif
    tick(); tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/npc_ras.md
Name: npc_ras

Overview:
- Parametrised next-PC unit for the multi-cycle MIPS core.
- Holds the PC register and computes the next PC from five sources: sequential, branch, register, jump and exception vector.
- Adds a circular return-address stack (RAS). The RAS records call return addresses and checks each architectural return target against its prediction.
- The predicted target is exported for a future prefetching front end.

Parameters:
- XLEN, 32: PC/data width in bits; ≥ 32.
- RESET_VEC, 32'h0000_0000: PC value while reset is held and after it is released.
- EXC_VEC, 32'h0000_0080: exception entry address.
- RAS_DEPTH, 4: RAS entries; power of two, ≥ 2.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- pc_wr  in  1  PC write enable; all state updates are qualified by it.
- pc_src  in  3  next-PC select: 0 seq, 1 branch, 2 reg, 3 jump, 4 return; 5-7 treated as seq.
- imm32  in  XLEN  sign-extended branch offset, in words.
- imm26  in  26  jump index.
- bus_a  in  XLEN  register-file rs value.
- exc  in  1  exception request; overrides pc_src.
- is_call  in  1  current instruction is jal/jalr.
- pc  out  XLEN  current PC (registered).
- pc4  out  XLEN  pc + 4 (combinational).
- next_pc  out  XLEN  selected next PC (combinational).
- ras_top  out  XLEN  predicted return address (top entry).
- ras_valid  out  1  RAS non-empty.
- ras_count  out  $clog2(RAS_DEPTH)+1  number of valid entries.
- ras_mispredict  out  1  registered one-cycle pulse on a return-target mismatch.
- ras_overflow  out  1  registered one-cycle pulse when a push overwrote the oldest entry.

Behaviour:
- Reset (async):
  - pc = RESET_VEC; ras_count = 0; pointer = 0.
  - ras_mispredict = 0; ras_overflow = 0.
  - While reset is high, next_pc = RESET_VEC.
  - RAS entry contents are don't-care; ras_top = 0 while empty.
- pc4 = pc + 4, modulo 2^XLEN.
- next_pc selection, in priority order:
  1. reset → RESET_VEC.
  2. exc → EXC_VEC.
  3. pc_src=1 → pc4 + (imm32 << 2), truncated to XLEN; wraps silently.
  4. pc_src=2 or 4 → bus_a.
  5. pc_src=3 → {pc4[XLEN-1:28], imm26, 2'b00}; upper bits come from pc4, never from next_pc.
  6. Otherwise → pc4.
- PC update: at the rising clk edge with pc_wr=1, pc ← next_pc. With pc_wr=0, pc holds and no RAS state changes.
- Return: is_ret = (pc_src==4). RAS activity requires pc_wr=1 and exc=0; an exception suppresses push, pop and flags.
- Push (is_call, not is_ret):
  - Write pc4 to the entry at ptr; ptr ← ptr+1 mod RAS_DEPTH.
  - count ← min(count+1, RAS_DEPTH).
  - If count was already RAS_DEPTH, the oldest entry is overwritten and ras_overflow pulses for one cycle.
- Pop (is_ret, not is_call):
  - If count>0: ptr ← ptr−1, count ← count−1. ras_mispredict ← (ras_top != bus_a), sampled before the pop.
  - If count==0: no state change; ras_mispredict ← 1 (underflow counts as a mispredict).
- Call and return together (jalr used as a return):
  - The mispredict check is as for a pop.
  - Then the top entry is replaced with pc4; count and ptr are unchanged.
  - If count==0, it behaves as a push.
- Flags are otherwise 0 at every edge, so each is exactly one cycle wide.
- ras_top = entry[ptr−1] when count>0, else 0. ras_valid = (count != 0).
- Latency: next_pc is combinational, zero cycles; pc and flags have one-cycle latency.

Optional Feature:
- Macro NPC_ALIGN_CHECK_EN.
- When defined:
  - When pc_src is 2 or 4, exc=0 and bus_a[1:0] != 0, next_pc = EXC_VEC.
  - An extra output port, misalign (1 bit, registered, reset 0), pulses for one cycle when pc_wr=1 in that condition.
  - The RAS is not updated on that edge.
- When undefined: no misalign port; bus_a is used unchanged.

Test Plan:
- Reset then seq: assert reset mid-run with pc=0x40 → pc=0 immediately. Release, pc_src=0, pc_wr=1 for 3 edges → pc = 4, 8, 0xC; pc_wr=0 → pc holds.
- Branch/jump: pc=0x1000, imm32=0xFFFF_FFFE, pc_src=1 → next_pc=0xFFC. pc=0x1000_0000, imm26=0x0000100, pc_src=3 → next_pc=0x1000_0400. pc=0xFFFF_FFFC, pc_src=0 → next_pc=0.
- RAS match: call at pc=0x100 (push 0x104), then pc_src=4 with bus_a=0x104 → pc=0x104, ras_mispredict=0, ras_count returns to 0.
- RAS overflow: 5 calls from pc 0x0, 0x10, 0x20, 0x30, 0x40 with RAS_DEPTH=4 → ras_overflow pulses on the 5th, count=4. The next 4 pops predict 0x44, 0x34, 0x24, 0x14; a 5th pop → ras_mispredict=1, count stays 0.
- Exception priority: exc=1 with is_call=1, pc_src=1 → pc=0x80, count unchanged, no flags. pc_wr=0 with is_ret=1 → no pop.
- NPC_ALIGN_CHECK_EN: pc_src=2, bus_a=0x202 → pc=0x80, misalign pulses once. Without the macro → pc=0x202.
